// File: rtl/decode_cycle.sv
// RV32I instruction-decode stage: control/immediate generation and the ID/EX pipeline register.
// Optional same-cycle write-back bypass into RD1E/RD2E is enabled by defining DECODE_WB_BYPASS_EN.
module decode_cycle #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            ValidD,
    output logic [4:0]      RS1D,
    output logic [4:0]      RS2D,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            StallE,
    input  logic            FlushE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            ALUSrcE,
    output logic            BranchE,
    output logic            JumpE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      RS1E,
    output logic [4:0]      RS2E,
    output logic [4:0]      RDE,
    output logic            ValidE,
    output logic            IllegalE
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [2:0] {
        OP_LOAD,
        OP_STORE,
        OP_RTYPE,
        OP_IALU,
        OP_BRANCH,
        OP_JAL,
        OP_BAD
    } op_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_e;

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            alu_src;
        logic            branch;
        logic            jump;
        logic [1:0]      result_src;
        logic [2:0]      alu_ctrl;
        logic            valid;
        logic            illegal;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } idex_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    op_e             op;
    imm_e            imm_sel;
    logic [XLEN-1:0] imm_ext;
    logic [2:0]      alu_fn;
    logic            f3_bad;
    logic [XLEN-1:0] rd1_fwd;
    logic [XLEN-1:0] rd2_fwd;
    idex_t           dec;
    idex_t           bubble;
    idex_t           idex_d;
    idex_t           idex_q;

    assign opcode   = InstrD[6:0];
    assign funct3   = InstrD[14:12];
    assign funct7b5 = InstrD[30];
    assign RS1D     = InstrD[19:15];
    assign RS2D     = InstrD[24:20];

    always_comb begin
        unique case (opcode)
            7'b0000011: op = OP_LOAD;
            7'b0100011: op = OP_STORE;
            7'b0110011: op = OP_RTYPE;
            7'b0010011: op = OP_IALU;
            7'b1100011: op = OP_BRANCH;
            7'b1101111: op = OP_JAL;
            default:    op = OP_BAD;
        endcase
    end

    // funct3 decode is only meaningful for R-type and I-ALU; sub needs R-type with funct7[5].
    always_comb begin
        f3_bad = 1'b0;
        unique case (funct3)
            3'b000:  alu_fn = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_fn = ALU_SLT;
            3'b110:  alu_fn = ALU_OR;
            3'b111:  alu_fn = ALU_AND;
            default: begin
                alu_fn = ALU_ADD;
                f3_bad = 1'b1;
            end
        endcase
    end

    always_comb begin
        unique case (imm_sel)
            IMM_I:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            IMM_S:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25],
                                InstrD[11:8], 1'b0};
            IMM_J:   imm_ext = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20],
                                InstrD[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

`ifdef DECODE_WB_BYPASS_EN
    // The register file writes on the same edge this stage captures, so its read data is stale.
    assign rd1_fwd = (RegWriteW && RDW != '0 && RDW == RS1D) ? ResultW : RD1D;
    assign rd2_fwd = (RegWriteW && RDW != '0 && RDW == RS2D) ? ResultW : RD2D;
`else
    logic unused_wb;
    assign unused_wb = ^{RegWriteW, RDW, ResultW};
    assign rd1_fwd   = RD1D;
    assign rd2_fwd   = RD2D;
`endif

    always_comb begin
        dec         = '0;
        imm_sel     = IMM_NONE;
        dec.alu_ctrl = ALU_ADD;
        unique case (op)
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b01;
                imm_sel        = IMM_I;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_sel       = IMM_S;
            end
            OP_RTYPE: begin
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = alu_fn;
                dec.illegal   = f3_bad;
            end
            OP_IALU: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = alu_fn;
                dec.illegal   = f3_bad;
                imm_sel       = IMM_I;
            end
            OP_BRANCH: begin
                dec.branch   = 1'b1;
                dec.alu_ctrl = ALU_SUB;
                imm_sel      = IMM_B;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = 2'b10;
                imm_sel        = IMM_J;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (!ValidD) begin
            dec = '0;
        end
        dec.valid = ValidD;
        dec.rs1   = RS1D;
        dec.rs2   = RS2D;
        dec.rd    = InstrD[11:7];
        dec.rd1   = rd1_fwd;
        dec.rd2   = rd2_fwd;
        dec.imm   = imm_ext;
        dec.pc    = PCD;
        dec.pc4   = PCPlus4D;
    end

    always_comb begin
        bubble    = '0;
        bubble.pc = RESET_PC;
    end

    always_comb begin
        idex_d = idex_q;
        if (FlushE) begin
            idex_d = bubble;
        end else if (!StallE) begin
            idex_d = dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= bubble;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign RegWriteE   = idex_q.reg_write;
    assign MemWriteE   = idex_q.mem_write;
    assign ALUSrcE     = idex_q.alu_src;
    assign BranchE     = idex_q.branch;
    assign JumpE       = idex_q.jump;
    assign ResultSrcE  = idex_q.result_src;
    assign ALUControlE = idex_q.alu_ctrl;
    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign ImmExtE     = idex_q.imm;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc4;
    assign RS1E        = idex_q.rs1;
    assign RS2E        = idex_q.rs2;
    assign RDE         = idex_q.rd;
    assign ValidE      = idex_q.valid;
    assign IllegalE    = idex_q.illegal;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed, table-driven bench for decode_cycle, plus stall/flush/reset and bypass sequences.
module tb_decode_cycle;

    localparam logic [31:0] RST_PC = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, RD1D, RD2D, ResultW;
    logic        ValidD, RegWriteW, StallE, FlushE;
    logic [4:0]  RDW, RS1D, RS2D;
    logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ValidE, IllegalE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  RS1E, RS2E, RDE;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    always #5 clk = ~clk;

    decode_cycle #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .RS1D(RS1D), .RS2D(RS2D), .RD1D(RD1D), .RD2D(RD2D),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .StallE(StallE), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
        .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE),
        .ValidE(ValidE), .IllegalE(IllegalE)
    );

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [4:0]  ctl;   // {RegWrite, MemWrite, ALUSrc, Branch, Jump}
        logic [1:0]  rsrc;
        logic [2:0]  alu;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    vec_t vecs[14];
    vec_t bub;

    function automatic vec_t mk(input logic [31:0] ins, input logic v, input logic [31:0] pc,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                                input logic [4:0] ctl, input logic [1:0] rsrc,
                                input logic [2:0] alu, input logic [31:0] imm, input logic ill);
        vec_t t;
        t.instr = ins; t.valid = v; t.pc = pc; t.pc4 = pc + 32'd4;
        t.rd1 = rd1; t.rd2 = rd2; t.rs1 = r1; t.rs2 = r2; t.rd = rd;
        t.ctl = ctl; t.rsrc = rsrc; t.alu = alu; t.imm = imm; t.ill = ill;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chk_e(input string tag, input vec_t v);
        chk({tag, ".RegWriteE"},   32'(RegWriteE),   32'(v.ctl[4]));
        chk({tag, ".MemWriteE"},   32'(MemWriteE),   32'(v.ctl[3]));
        chk({tag, ".ALUSrcE"},     32'(ALUSrcE),     32'(v.ctl[2]));
        chk({tag, ".BranchE"},     32'(BranchE),     32'(v.ctl[1]));
        chk({tag, ".JumpE"},       32'(JumpE),       32'(v.ctl[0]));
        chk({tag, ".ResultSrcE"},  32'(ResultSrcE),  32'(v.rsrc));
        chk({tag, ".ALUControlE"}, 32'(ALUControlE), 32'(v.alu));
        chk({tag, ".ImmExtE"},     ImmExtE,          v.imm);
        chk({tag, ".RD1E"},        RD1E,             v.rd1);
        chk({tag, ".RD2E"},        RD2E,             v.rd2);
        chk({tag, ".PCE"},         PCE,              v.pc);
        chk({tag, ".PCPlus4E"},    PCPlus4E,         v.pc4);
        chk({tag, ".RS1E"},        32'(RS1E),        32'(v.rs1));
        chk({tag, ".RS2E"},        32'(RS2E),        32'(v.rs2));
        chk({tag, ".RDE"},         32'(RDE),         32'(v.rd));
        chk({tag, ".ValidE"},      32'(ValidE),      32'(v.valid));
        chk({tag, ".IllegalE"},    32'(IllegalE),    32'(v.ill));
    endtask

    task automatic drive(input vec_t v);
        InstrD = v.instr; ValidD = v.valid; PCD = v.pc; PCPlus4D = v.pc + 32'd4;
        RD1D = v.rd1; RD2D = v.rd2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //             instr          V  pc      rd1       rd2       rs1 rs2 rd  ctl       rsrc   alu     imm            ill
        vecs[0]  = mk(32'h0080A283, 1, 32'h100, 32'd17,   32'd99,   1,  8,  5,  5'b10100, 2'b01, 3'b000, 32'd8,         0); // lw
        vecs[1]  = mk(32'hFE21AE23, 1, 32'h104, 32'd3,    32'd55,   3,  2,  28, 5'b01100, 2'b00, 3'b000, 32'hFFFFFFFC,  0); // sw
        vecs[2]  = mk(32'hFE208CE3, 1, 32'h108, 32'd1,    32'd2,    1,  2,  25, 5'b00010, 2'b00, 3'b001, 32'hFFFFFFF8,  0); // beq
        vecs[3]  = mk(32'h402081B3, 1, 32'h10C, 32'd40,   32'd41,   1,  2,  3,  5'b10000, 2'b00, 3'b001, 32'd0,         0); // sub
        vecs[4]  = mk(32'h002082B3, 1, 32'h110, 32'd5,    32'd6,    1,  2,  5,  5'b10000, 2'b00, 3'b000, 32'd0,         0); // add
        vecs[5]  = mk(32'hFFF0E313, 1, 32'h114, 32'hA5,   32'h5A,   1,  31, 6,  5'b10100, 2'b00, 3'b011, 32'hFFFFFFFF,  0); // ori
        vecs[6]  = mk(32'h0020F3B3, 1, 32'h118, 32'd7,    32'd8,    1,  2,  7,  5'b10000, 2'b00, 3'b010, 32'd0,         0); // and
        vecs[7]  = mk(32'h0020A433, 1, 32'h11C, 32'd9,    32'd10,   1,  2,  8,  5'b10000, 2'b00, 3'b101, 32'd0,         0); // slt
        vecs[8]  = mk(32'h00109093, 1, 32'h120, 32'd11,   32'd12,   1,  1,  1,  5'b10100, 2'b00, 3'b000, 32'd1,         1); // slli: bad funct3
        vecs[9]  = mk(32'h010000EF, 1, 32'h124, 32'd13,   32'd14,   0,  16, 1,  5'b10001, 2'b10, 3'b000, 32'd16,        0); // jal
        vecs[10] = mk(32'h0000057F, 1, 32'h128, 32'd15,   32'd16,   0,  0,  10, 5'b00000, 2'b00, 3'b000, 32'd0,         1); // bad opcode
        vecs[11] = mk(32'h0080A283, 0, 32'h12C, 32'd17,   32'd18,   1,  8,  5,  5'b00000, 2'b00, 3'b000, 32'd8,         0); // lw, not valid
        vecs[12] = mk(32'h80000093, 1, 32'h130, 32'd19,   32'd20,   0,  0,  1,  5'b10100, 2'b00, 3'b000, 32'hFFFFF800,  0); // addi -2048
        vecs[13] = mk(32'h40000093, 1, 32'h134, 32'd21,   32'd22,   0,  0,  1,  5'b10100, 2'b00, 3'b000, 32'h00000400,  0); // addi, bit30 set
        bub = mk(32'h0, 0, RST_PC, 32'd0, 32'd0, 0, 0, 0, 5'b00000, 2'b00, 3'b000, 32'd0, 0);
        bub.pc4 = 32'd0;

        rst = 1'b1; StallE = 1'b0; FlushE = 1'b0;
        RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'd0;
        drive(vecs[0]);
        step(); step();
        chk_e("reset", bub);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d.RS1D", i), 32'(RS1D), 32'(vecs[i].instr[19:15]));
            chk($sformatf("v%0d.RS2D", i), 32'(RS2D), 32'(vecs[i].instr[24:20]));
            step();
            chk_e($sformatf("v%0d", i), vecs[i]);
        end

        // Stall holds the add while InstrD keeps changing; then flush beats stall.
        drive(vecs[4]);
        step();
        chk_e("preStall", vecs[4]);
        StallE = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(vecs[k]);
            step();
            chk_e($sformatf("stall%0d", k), vecs[4]);
        end
        FlushE = 1'b1;
        step();
        chk_e("flushStall", bub);
        FlushE = 1'b0; StallE = 1'b0;
        drive(vecs[0]);
        step();
        chk_e("afterFlush", vecs[0]);

        // Reset during a stall clears the register; the next instruction then loads normally.
        StallE = 1'b1;
        drive(vecs[1]);
        step();
        chk_e("stallHold", vecs[0]);
        rst = 1'b1;
        step();
        chk_e("rstInStall", bub);
        rst = 1'b0; StallE = 1'b0;
        drive(vecs[5]);
        step();
        chk_e("afterRst", vecs[5]);

        // Write-back bypass cases.
        drive(vecs[0]);
        RegWriteW = 1'b1; RDW = 5'd1; ResultW = 32'hDEAD_BEEF;
        step();
`ifdef DECODE_WB_BYPASS_EN
        chk("byp.rd1Hit", RD1E, 32'hDEAD_BEEF);
`else
        chk("byp.rd1Hit", RD1E, 32'd17);
`endif
        chk("byp.rd2Miss", RD2E, 32'd99);
        RDW = 5'd0;
        step();
        chk("byp.rdw0", RD1E, 32'd17);
        drive(vecs[9]);          // jal: RS1D = x0, so even RDW==RS1D must not bypass
        RD1D = 32'd17;
        step();
        chk("byp.x0", RD1E, 32'd17);
        drive(vecs[4]);
        RDW = 5'd2;
        step();
        chk("byp.rd1Keep", RD1E, 32'd5);
`ifdef DECODE_WB_BYPASS_EN
        chk("byp.rd2Hit", RD2E, 32'hDEAD_BEEF);
`else
        chk("byp.rd2Hit", RD2E, 32'd6);
`endif
        RegWriteW = 1'b0;
        step();
        chk("byp.weOff", RD2E, 32'd6);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
